// File: rtl/scan_unload_pkg.sv
// Shared types and helpers for the scan unload serializer.
// Parity slot is present when SCAN_UNLOAD_PARITY_EN is defined.
package scan_unload_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_SHIFT = SHIFT;

`ifdef SCAN_UNLOAD_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_CNT_W = $clog2(MAX_WIDTH + 1);

    // The counter must reach WIDTH so the parity slot can be addressed.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 32'd1);
    endfunction

    function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
        return width + (parity_en ? 32'd1 : 32'd0);
    endfunction

    function automatic logic even_parity64(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/scan_unload_ser_if.sv
// Load handshake and serial output bundle of the scan unload serializer.
interface scan_unload_ser_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] D;
    logic             LOAD_VALID;
    logic             LOAD_READY;
    logic             SHIFT_EN;
    logic             SO;
    logic             SO_VALID;
    logic             SO_LAST;
    logic             BUSY;

    modport master (
        output D, LOAD_VALID, SHIFT_EN,
        input  LOAD_READY, SO, SO_VALID, SO_LAST, BUSY
    );

    modport slave (
        input  D, LOAD_VALID, SHIFT_EN,
        output LOAD_READY, SO, SO_VALID, SO_LAST, BUSY
    );
endinterface

// File: rtl/scan_unload_bitsel.sv
// Picks the frame bit addressed by a slot counter: data bits in LSB- or
// MSB-first order, then the parity slot when SCAN_UNLOAD_PARITY_EN is defined.
module scan_unload_bitsel #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CW        = 4
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [CW-1:0]    cnt_i,
`ifdef SCAN_UNLOAD_PARITY_EN
    input  logic             par_i,
`endif
    output logic             bit_o
);
    localparam logic [CW-1:0] MSB_IDX    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DATA_SLOTS = CW'(WIDTH);

    logic [CW-1:0]    idx_s;
    logic [WIDTH-1:0] shifted_s;

    // Slot-to-bit selection; slots at or beyond WIDTH carry parity (or 0).
    always_comb begin
        idx_s     = cnt_i;
        shifted_s = word_i;
        bit_o     = 1'b0;
        if (LSB_FIRST) begin
            idx_s = cnt_i;
        end else begin
            idx_s = MSB_IDX - cnt_i;
        end
        shifted_s = word_i >> idx_s;
        if (cnt_i >= DATA_SLOTS) begin
`ifdef SCAN_UNLOAD_PARITY_EN
            bit_o = par_i;
`else
            bit_o = 1'b0;
`endif
        end else begin
            bit_o = shifted_s[0];
        end
    end
endmodule

// File: rtl/scan_unload_ser.sv
// Parallel-in / serial-out scan unload transmitter with valid/ready load and
// SHIFT_EN flow control. Define SCAN_UNLOAD_PARITY_EN to append an even-parity slot.
module scan_unload_ser
    import scan_unload_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RN,
    scan_unload_ser_if.slave bus
);
    localparam int unsigned   CW        = cnt_width(WIDTH);
    localparam int unsigned   FLEN      = frame_len(WIDTH, PARITY_EN);
    localparam logic [CW-1:0] LAST_SLOT = CW'(FLEN - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             so_q, so_d;
    logic             so_valid_q, so_valid_d;
    logic             so_last_q, so_last_d;
`ifdef SCAN_UNLOAD_PARITY_EN
    logic             par_q, par_d;
    logic             sel_par_s;
`endif

    logic             load_ready_s;
    logic             accept_s;
    logic             advance_s;
    logic             finish_s;
    logic [WIDTH-1:0] sel_word_s;
    logic [CW-1:0]    sel_cnt_s;
    logic             sel_bit_s;

    assign load_ready_s = (state_q == ST_IDLE) | (so_last_q & bus.SHIFT_EN);
    assign accept_s     = bus.LOAD_VALID & load_ready_s;
    assign advance_s    = (state_q == ST_SHIFT) & bus.SHIFT_EN & ~so_last_q;
    assign finish_s     = so_last_q & bus.SHIFT_EN;

    // A fresh load addresses slot 0 of D; otherwise the next slot of the held word.
    always_comb begin
        sel_word_s = word_q;
        sel_cnt_s  = cnt_q + CW'(1);
`ifdef SCAN_UNLOAD_PARITY_EN
        sel_par_s  = par_q;
`endif
        if (accept_s) begin
            sel_word_s = bus.D;
            sel_cnt_s  = {CW{1'b0}};
`ifdef SCAN_UNLOAD_PARITY_EN
            sel_par_s  = even_parity64(64'(bus.D));
`endif
        end else begin
            sel_word_s = word_q;
        end
    end

    scan_unload_bitsel #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST),
        .CW        (CW)
    ) u_bitsel (
        .word_i (sel_word_s),
        .cnt_i  (sel_cnt_s),
`ifdef SCAN_UNLOAD_PARITY_EN
        .par_i  (sel_par_s),
`endif
        .bit_o  (sel_bit_s)
    );

    // Frame sequencing: load (including back-to-back), advance, or end of frame.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        so_d       = so_q;
        so_valid_d = so_valid_q;
        so_last_d  = so_last_q;
`ifdef SCAN_UNLOAD_PARITY_EN
        par_d      = par_q;
`endif
        if (accept_s) begin
            state_d    = ST_SHIFT;
            word_d     = bus.D;
            cnt_d      = {CW{1'b0}};
            so_d       = sel_bit_s;
            so_valid_d = 1'b1;
            so_last_d  = (sel_cnt_s == LAST_SLOT);
`ifdef SCAN_UNLOAD_PARITY_EN
            par_d      = sel_par_s;
`endif
        end else if (advance_s) begin
            cnt_d      = sel_cnt_s;
            so_d       = sel_bit_s;
            so_last_d  = (sel_cnt_s == LAST_SLOT);
        end else if (finish_s) begin
            state_d    = ST_IDLE;
            word_d     = {WIDTH{1'b0}};
            cnt_d      = {CW{1'b0}};
            so_d       = 1'b0;
            so_valid_d = 1'b0;
            so_last_d  = 1'b0;
`ifdef SCAN_UNLOAD_PARITY_EN
            par_d      = 1'b0;
`endif
        end else begin
            state_d    = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= ST_IDLE;
            word_q     <= {WIDTH{1'b0}};
            cnt_q      <= {CW{1'b0}};
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            so_last_q  <= 1'b0;
`ifdef SCAN_UNLOAD_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            so_last_q  <= so_last_d;
`ifdef SCAN_UNLOAD_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.LOAD_READY = load_ready_s;
    assign bus.SO         = so_q;
    assign bus.SO_VALID   = so_valid_q;
    assign bus.SO_LAST    = so_last_q;
    assign bus.BUSY       = so_valid_q;
endmodule

// File: tb/tb_scan_unload_ser.sv
// Bench for scan_unload_ser: LSB-first and MSB-first instances share stimulus;
// a queue model of the remaining frame bits is checked every cycle.
module tb_scan_unload_ser;
    import scan_unload_pkg::*;

    localparam int FLEN = frame_len(8, PARITY_EN);

`ifdef SCAN_UNLOAD_PARITY_EN
    localparam logic [31:0] E_A5   = 32'h0000_014A;
    localparam logic [31:0] E_3C   = 32'h0000_0078;
    localparam logic [31:0] E_0F_L = 32'h0000_01E0;
    localparam logic [31:0] E_0F_M = 32'h0000_001E;
    localparam logic [31:0] E_B2B  = 32'h0003_FC00;
`else
    localparam logic [31:0] E_A5   = 32'h0000_00A5;
    localparam logic [31:0] E_3C   = 32'h0000_003C;
    localparam logic [31:0] E_0F_L = 32'h0000_00F0;
    localparam logic [31:0] E_0F_M = 32'h0000_000F;
    localparam logic [31:0] E_B2B  = 32'h0000_FF00;
`endif

    logic clk = 1'b0;
    logic rn  = 1'b0;
    always #5 clk = ~clk;

    scan_unload_ser_if #(.WIDTH(8)) if_l ();
    scan_unload_ser_if #(.WIDTH(8)) if_m ();

    scan_unload_ser #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (.CLK(clk), .RN(rn), .bus(if_l.slave));
    scan_unload_ser #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (.CLK(clk), .RN(rn), .bus(if_m.slave));

    int n_checks = 0;
    int n_fail   = 0;
    logic q_l[$];
    logic q_m[$];
    logic [31:0] seq_l, seq_m;
    int nbits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {SO, SO_VALID, SO_LAST, BUSY, LOAD_READY} from the remaining-bit queue.
    function automatic logic [4:0] exp_outs(input int sz, input logic head, input logic se);
        logic v;
        v = (sz != 0);
        return {v ? head : 1'b0, v, (sz == 1), v, (!v) || ((sz == 1) && se)};
    endfunction

    always @(negedge clk) begin
        check("outs_lsb", {27'b0, if_l.SO, if_l.SO_VALID, if_l.SO_LAST, if_l.BUSY, if_l.LOAD_READY},
              {27'b0, exp_outs(q_l.size(), (q_l.size() != 0) ? q_l[0] : 1'b0, if_l.SHIFT_EN)});
        check("outs_msb", {27'b0, if_m.SO, if_m.SO_VALID, if_m.SO_LAST, if_m.BUSY, if_m.LOAD_READY},
              {27'b0, exp_outs(q_m.size(), (q_m.size() != 0) ? q_m[0] : 1'b0, if_m.SHIFT_EN)});
    end

    task automatic load_model(input logic [7:0] d);
        q_l.delete();
        q_m.delete();
        for (int i = 0; i < 8; i++) begin
            q_l.push_back(d[i]);
            q_m.push_back(d[7-i]);
        end
`ifdef SCAN_UNLOAD_PARITY_EN
        q_l.push_back(^d);
        q_m.push_back(^d);
`endif
    endtask

    task automatic model_edge();
        if (!rn) begin
            q_l.delete();
            q_m.delete();
        end else if (if_l.LOAD_VALID && (q_l.size() == 0 || (q_l.size() == 1 && if_l.SHIFT_EN))) begin
            load_model(if_l.D);
        end else if (q_l.size() != 0 && if_l.SHIFT_EN) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
        end
    endtask

    task automatic drive(input logic lv, input logic [7:0] d, input logic se);
        if_l.LOAD_VALID = lv; if_l.D = d; if_l.SHIFT_EN = se;
        if_m.LOAD_VALID = lv; if_m.D = d; if_m.SHIFT_EN = se;
    endtask

    // One clock: model follows the edge, new inputs applied, consumed bits recorded.
    task automatic cycle(input logic lv, input logic [7:0] d, input logic se);
        @(posedge clk);
        model_edge();
        #1;
        drive(lv, d, se);
        @(negedge clk);
        #1;
        if (if_l.SO_VALID && if_l.SHIFT_EN) begin
            seq_l = {seq_l[30:0], if_l.SO};
            nbits++;
        end
        if (if_m.SO_VALID && if_m.SHIFT_EN) seq_m = {seq_m[30:0], if_m.SO};
    endtask

    task automatic clear_seq();
        seq_l = 32'h0; seq_m = 32'h0; nbits = 0;
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [31:0] el, input logic [31:0] em, input string name);
        clear_seq();
        cycle(1'b1, d, 1'b1);
        repeat (FLEN) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check({name, "_seq_lsb"}, seq_l, el);
        check({name, "_seq_msb"}, seq_m, em);
        check({name, "_nbits"}, nbits, FLEN);
        check({name, "_idle"}, {31'b0, if_l.SO_VALID}, 32'h0);
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0);
        clear_seq();
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        check("reset_ready", {31'b0, if_l.LOAD_READY}, 32'h1);
        check("reset_valid", {31'b0, if_l.SO_VALID}, 32'h0);
        rn = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);

        run_frame(8'hA5, E_A5, E_A5, "basic_a5");

        // MSB/LSB order with SHIFT_EN pattern 1,0,0,1 repeating
        clear_seq();
        cycle(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 24; i++) cycle(1'b0, 8'h00, (i % 4 == 0) || (i % 4 == 3));
        check("stall_seq_lsb", seq_l, E_3C);
        check("stall_seq_msb", seq_m, E_3C);
        check("stall_nbits", nbits, FLEN);

        // Back-to-back frames with no SO_VALID gap
        clear_seq();
        cycle(1'b1, 8'hFF, 1'b1);
        repeat (FLEN - 1) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h00, 1'b1);
        repeat (FLEN) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("b2b_seq_lsb", seq_l, E_B2B);
        check("b2b_seq_msb", seq_m, E_B2B);
        check("b2b_nbits", nbits, 2 * FLEN);

        // Load attempt mid-frame is ignored; D changes after load do not matter
        clear_seq();
        cycle(1'b1, 8'h0F, 1'b1);
        cycle(1'b0, 8'hFF, 1'b1);
        cycle(1'b0, 8'hFF, 1'b1);
        cycle(1'b1, 8'h12, 1'b1);
        check("ign_ready", {31'b0, if_l.LOAD_READY}, 32'h0);
        repeat (FLEN - 3) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("ign_seq_lsb", seq_l, E_0F_L);
        check("ign_seq_msb", seq_m, E_0F_M);
        check("ign_idle", {31'b0, if_l.SO_VALID}, 32'h0);

        // Asynchronous reset after three bits of A5
        clear_seq();
        cycle(1'b1, 8'hA5, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        @(posedge clk);
        model_edge();
        #1;
        rn = 1'b0;
        q_l.delete();
        q_m.delete();
        drive(1'b0, 8'h00, 1'b1);
        #1;
        check("rst_so", {31'b0, if_l.SO}, 32'h0);
        check("rst_valid", {31'b0, if_m.SO_VALID}, 32'h0);
        check("rst_ready", {31'b0, if_l.LOAD_READY}, 32'h1);
        nbits = 0;
        repeat (2) cycle(1'b0, 8'h00, 1'b1);
        rn = 1'b1;
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        check("rst_no_bits", nbits, 0);

`ifdef SCAN_UNLOAD_PARITY_EN
        run_frame(8'h07, 32'h0000_01C1, 32'h0000_000F, "par_07");
        run_frame(8'h03, 32'h0000_0180, 32'h0000_0006, "par_03");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/scan_unload_ser.md
Name: scan_unload_ser

Overview:
Parallel-in / serial-out scan unload transmitter, the read side of our flop capture chains.
- Accepts a WIDTH-bit word captured by the chain's D/Q flops through a valid/ready load handshake.
- Shifts the word out one bit per accepted SHIFT_EN cycle, with frame-last marking.
- Sits between characterization capture registers and the tester serial pin.
- Single rising-edge clock domain.

Parameters:
- WIDTH, 8, captured word width in bits; legal range 2..64.
- LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit WIDTH-1 shifted first.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- D  input  WIDTH  parallel word to unload.
- LOAD_VALID  input  1  D is valid and requests a load.
- LOAD_READY  output  1  block can accept a word this cycle.
- SHIFT_EN  input  1  downstream consumes the current SO bit at this edge; 0 = stall.
- SO  output  1  current serial bit, registered.
- SO_VALID  output  1  SO holds a frame bit.
- SO_LAST  output  1  SO is the final bit of the frame.
- BUSY  output  1  frame in progress; equals SO_VALID.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. The clock port is CLK and the reset port is RN.
- Reset, while RN=0 and immediately after it: state=IDLE, shift reg=0, bit counter=0, SO=0, SO_VALID=0, SO_LAST=0, BUSY=0, LOAD_READY=1.
- Reset mid-frame aborts the frame with no further bits; the first edge after RN rises behaves as IDLE.
- FSM states: IDLE, SHIFT.
- IDLE:
  - LOAD_READY=1.
  - On LOAD_VALID=1 at an edge: capture D, go to SHIFT, set counter=0, drive SO=first bit, SO_VALID=1.
  - Latency from load edge to first SO bit: 0 cycles; the bit is visible in the cycle after the load edge.
- SHIFT:
  - SHIFT_EN=1 at an edge: advance to the next bit and increment the counter.
  - SHIFT_EN=0: SO, SO_LAST and counter hold indefinitely.
  - SO_LAST=1 exactly when counter==WIDTH-1 (or the parity slot when enabled).
- Frame end, SO_LAST=1 and SHIFT_EN=1:
  - If LOAD_VALID=1 in the same cycle, the new word loads and shifting continues with no gap (back-to-back).
  - Otherwise go to IDLE and clear SO_VALID and SO.
- LOAD_READY = (state==IDLE) | (SO_LAST & SHIFT_EN). It is combinational from state and SHIFT_EN only, never from LOAD_VALID.
- LOAD_VALID with LOAD_READY=0 is ignored. D is sampled only at the accepting edge; later changes to D do not affect the frame.
- Counter width is $clog2(WIDTH+1). It never wraps past the last slot.

Optional Feature:
- Macro SCAN_UNLOAD_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH captured bits) is appended as slot WIDTH.
  - The frame is WIDTH+1 bits; SO_LAST marks the parity slot.
  - Parity is computed at the load edge and stored.
- Undefined: frame is exactly WIDTH bits; no parity logic or storage is synthesized.

Decomposition:
- Shared package scan_unload_pkg:
  - state enum (IDLE, SHIFT);
  - function frame_len(WIDTH, parity_en);
  - localparam for counter width.
- One natural sub-module: scan_unload_bitsel. Combinational selection of the current bit (counter + LSB_FIRST + parity slot) -> next SO value. The top level keeps the FSM, counter and registers.

Test Plan:
- Reset: RN low mid-frame after 3 bits of 8'hA5 -> SO=0, SO_VALID=0, LOAD_READY=1 immediately; no further bits after RN rises.
- Basic frame: WIDTH=8, LSB_FIRST=1, load 8'hA5, SHIFT_EN held 1 -> SO sequence 1,0,1,0,0,1,0,1; SO_LAST only on the 8th bit; IDLE the next cycle.
- MSB-first with stalls: LSB_FIRST=0, load 8'h3C, SHIFT_EN toggled 1,0,0,1,... -> SO sequence 0,0,1,1,1,1,0,0; each bit holds during stall cycles.
- Back-to-back: load 8'hFF, then present 8'h00 with LOAD_VALID during the SO_LAST & SHIFT_EN cycle -> 16 consecutive valid bits (8 ones then 8 zeros) with no SO_VALID gap.
- Ignored load: assert LOAD_VALID with D=8'h12 while shifting at bit 2 -> LOAD_READY=0; the frame is unchanged and 8'h12 is not loaded.
- Parity, with SCAN_UNLOAD_PARITY_EN: load 8'h07 -> 9-bit frame ending with parity bit 1 and SO_LAST on the 9th bit; load 8'h03 -> parity bit 0.
